// File: rtl/fir_tap_pkt_gen.sv
// Collects one track of FIR taps into a local store, then emits header + TAP_NUM taps in one cmd window.
// Optional macro FIR_TAP_CSUM_EN: a trailing checksum word per track must match the tap sum.
module fir_tap_pkt_gen #(
   parameter real         TCQ          = 0.1,
   parameter int unsigned TAP_NUM      = 127,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter logic [31:0] TRACK_STRIDE = 32'd512,
   parameter int unsigned IDX_WIDTH    = 16,
   parameter int unsigned GAP_CYCLES   = 4
) (
   input  logic                 sys_clk_i,
   input  logic                 sys_rst_i,
   input  logic                 tap_start_i,
   input  logic [IDX_WIDTH-1:0] tap_track_idx_i,
   input  logic                 tap_vld_i,
   input  logic [31:0]          tap_data_i,
   output logic                 busy_o,
   output logic                 tap_err_o,
   output logic                 csum_err_o,
   output logic                 fir_tap_wr_cmd_o,
   output logic                 fir_tap_wr_vld_o,
   output logic [31:0]          fir_tap_wr_data_o
);

   if (TAP_NUM + 1 != 128) begin : g_bad_tap_num
      $error("TAP_NUM+1 must equal 128");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be at least 1");
   end
   if (TCQ < 0.0) begin : g_bad_tcq
      $error("TCQ must not be negative");
   end

`ifdef FIR_TAP_CSUM_EN
   localparam int unsigned NUM_IN = TAP_NUM + 1;
`else
   localparam int unsigned NUM_IN = TAP_NUM;
`endif
   localparam int unsigned CNT_W = $clog2(NUM_IN + 1);
   localparam int unsigned RD_W  = $clog2(TAP_NUM + 1);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

   // wr_cnt reaches WR_LAST once every word of the track has been taken
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(NUM_IN);
   localparam logic [CNT_W-1:0] WR_TAPS = CNT_W'(TAP_NUM);
   localparam logic [RD_W-1:0]  RD_END  = RD_W'(TAP_NUM);
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_CYCLES - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_COLLECT = 3'd1;
   localparam logic [2:0] ST_HEAD    = 3'd2;
   localparam logic [2:0] ST_BODY    = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]      hdr_q, hdr_d;
   logic             tap_err_q, tap_err_d;
   logic             mem_we, rd_en;
   logic [31:0]      rd_data_q;
   logic [31:0]      tap_mem [TAP_NUM];
`ifdef FIR_TAP_CSUM_EN
   logic [31:0]      sum_q, sum_d;
   logic             csum_ok_q, csum_ok_d;
   logic             csum_err_q, csum_err_d;
`endif

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      gap_cnt_d = gap_cnt_q;
      hdr_d     = hdr_q;
      tap_err_d = 1'b0;
      mem_we    = 1'b0;
`ifdef FIR_TAP_CSUM_EN
      sum_d      = sum_q;
      csum_ok_d  = csum_ok_q;
      csum_err_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            tap_err_d = tap_vld_i;
            if (tap_start_i) begin
               hdr_d    = BASE_ADDR + 32'(tap_track_idx_i) * TRACK_STRIDE;
               wr_cnt_d = '0;
`ifdef FIR_TAP_CSUM_EN
               sum_d     = '0;
               csum_ok_d = 1'b0;
`endif
               state_d  = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (wr_cnt_q == WR_LAST) begin
               tap_err_d = tap_vld_i | tap_start_i;
               rd_cnt_d  = '0;
`ifdef FIR_TAP_CSUM_EN
               if (csum_ok_q) begin
                  state_d = ST_HEAD;
               end else begin
                  csum_err_d = 1'b1;
                  state_d    = ST_IDLE;
               end
`else
               state_d   = ST_HEAD;
`endif
            end else begin
               tap_err_d = tap_start_i;
               if (tap_vld_i) begin
                  mem_we   = (wr_cnt_q < WR_TAPS);
                  wr_cnt_d = wr_cnt_q + 1'b1;
`ifdef FIR_TAP_CSUM_EN
                  if (wr_cnt_q < WR_TAPS) begin
                     sum_d = sum_q + tap_data_i;
                  end else begin
                     csum_ok_d = (tap_data_i == sum_q);
                  end
`endif
               end
            end
         end
         ST_HEAD: begin
            tap_err_d = tap_vld_i | tap_start_i;
            rd_cnt_d  = rd_cnt_q + 1'b1;
            state_d   = ST_BODY;
         end
         ST_BODY: begin
            tap_err_d = tap_vld_i | tap_start_i;
            if (rd_cnt_q == RD_END) begin
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               rd_cnt_d = rd_cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            tap_err_d = tap_vld_i | tap_start_i;
            if (gap_cnt_q == GAP_END) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q   <= ST_IDLE;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         gap_cnt_q <= '0;
         hdr_q     <= '0;
         tap_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         hdr_q     <= hdr_d;
         tap_err_q <= tap_err_d;
      end
   end

`ifdef FIR_TAP_CSUM_EN
   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         sum_q      <= '0;
         csum_ok_q  <= 1'b0;
         csum_err_q <= 1'b0;
      end else begin
         sum_q      <= sum_d;
         csum_ok_q  <= csum_ok_d;
         csum_err_q <= csum_err_d;
      end
   end
   assign csum_err_o = csum_err_q;
`else
   assign csum_err_o = 1'b0;
`endif

   // Tap store is left intact by reset; the read is issued one cycle ahead of the output slot
   assign rd_en = (state_q == ST_HEAD) || ((state_q == ST_BODY) && (rd_cnt_q != RD_END));

   always_ff @(posedge sys_clk_i) begin
      if (mem_we) begin
         tap_mem[wr_cnt_q[RD_W-1:0]] <= tap_data_i;
      end
      if (rd_en) begin
         rd_data_q <= tap_mem[rd_cnt_q];
      end
   end

   assign busy_o            = (state_q != ST_IDLE);
   assign tap_err_o         = tap_err_q;
   assign fir_tap_wr_cmd_o  = (state_q == ST_HEAD) || (state_q == ST_BODY);
   assign fir_tap_wr_vld_o  = fir_tap_wr_cmd_o;
   assign fir_tap_wr_data_o = (state_q == ST_HEAD) ? hdr_q :
                              (state_q == ST_BODY) ? rd_data_q : 32'h0;

endmodule

// File: tb/tb_fir_tap_pkt_gen.sv
// Randomized bench for fir_tap_pkt_gen: expected packets are built from the driven taps and track index.
module tb_fir_tap_pkt_gen;
   localparam int unsigned TAP_NUM      = 127;
   localparam int unsigned GAP_CYCLES   = 4;
   localparam logic [31:0] BASE_ADDR    = 32'h0000_0000;
   localparam logic [31:0] TRACK_STRIDE = 32'd512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] track_idx = '0;
   logic        vld = 1'b0;
   logic [31:0] data = '0;
   logic        busy, tap_err, csum_err, cmd, wr_vld;
   logic [31:0] wr_data;

   fir_tap_pkt_gen #(
      .TAP_NUM      (TAP_NUM),
      .BASE_ADDR    (BASE_ADDR),
      .TRACK_STRIDE (TRACK_STRIDE),
      .IDX_WIDTH    (16),
      .GAP_CYCLES   (GAP_CYCLES)
   ) dut (
      .sys_clk_i         (clk),
      .sys_rst_i         (rst),
      .tap_start_i       (start),
      .tap_track_idx_i   (track_idx),
      .tap_vld_i         (vld),
      .tap_data_i        (data),
      .busy_o            (busy),
      .tap_err_o         (tap_err),
      .csum_err_o        (csum_err),
      .fir_tap_wr_cmd_o  (cmd),
      .fir_tap_wr_vld_o  (wr_vld),
      .fir_tap_wr_data_o (wr_data)
   );

   always #5 clk = ~clk;

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   // Monitor: samples 1 time unit after each edge, records emitted words and pulse counts.
   int unsigned cyc = 0;
   logic [31:0] got_q[$];
   int unsigned got_cyc_q[$];
   int unsigned run_q[$];
   int unsigned err_pulses = 0;
   int unsigned csum_pulses = 0;
   int unsigned cmd_run = 0;
   int unsigned low_run = 0;
   bit          seen_pkt = 1'b0;

   always @(posedge clk) begin
      #1;
      cyc++;
      check_eq("vld_follows_cmd", {31'b0, wr_vld}, {31'b0, cmd});
      if (!wr_vld) check_eq("data_zero_idle", wr_data, 32'h0);
      if (wr_vld) begin
         got_q.push_back(wr_data);
         got_cyc_q.push_back(cyc);
      end
      if (tap_err) err_pulses++;
      if (csum_err) csum_pulses++;
      if (cmd) begin
         if (cmd_run == 0 && seen_pkt)
            check_eq("gap_min", {31'b0, (low_run >= GAP_CYCLES)}, 32'h1);
         cmd_run++;
         low_run = 0;
      end else begin
         if (cmd_run != 0) begin
            run_q.push_back(cmd_run);
            seen_pkt = 1'b1;
         end
         cmd_run = 0;
         low_run++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] taps [TAP_NUM];

   // Drives start, then the taps (and checksum when enabled); k is the edge sampling the last word.
   task automatic drive_track(input logic [15:0] idx, input int mode, input int start_at,
                              input bit bad_csum, output int unsigned k, output int unsigned n_err);
      int unsigned gaps;
      int unsigned n_words;
      logic [31:0] sum;
      n_err = 0;
      sum = '0;
`ifdef FIR_TAP_CSUM_EN
      n_words = TAP_NUM + 1;
`else
      n_words = TAP_NUM;
`endif
      start = 1'b1;
      track_idx = idx;
      tick();
      start = 1'b0;
      track_idx = 16'($urandom);
      k = 0;
      for (int i = 0; i < int'(n_words); i++) begin
         gaps = (mode == 0) ? 0 : (mode == 1) ? 2 : $urandom_range(0, 3);
         for (int g = 0; g < int'(gaps); g++) begin
            vld = 1'b0;
            data = $urandom;
            tick();
         end
         vld = 1'b1;
         if (i < int'(TAP_NUM)) begin
            data = taps[i];
            sum = sum + taps[i];
         end else begin
            data = bad_csum ? sum + 32'd1 : sum;
         end
         if (i == start_at) begin
            start = 1'b1;
            track_idx = idx ^ 16'h0005;
            n_err++;
         end
         k = cyc + 1;
         tick();
         start = 1'b0;
      end
      vld = 1'b0;
      data = '0;
   endtask

   task automatic wait_idle(input string tag);
      int unsigned budget;
      budget = 0;
      while (busy && budget < 800) begin
         tick();
         budget++;
      end
      check_eq({tag, "_busy_done"}, {31'b0, busy}, 32'h0);
   endtask

   task automatic send_track(input logic [15:0] idx, input int mode, input int start_at,
                             input bit bad_csum, input bit poke_body);
      int unsigned k, exp_err, err0, csum0, budget;
      logic [31:0] exp_pkt[$];
      err0 = err_pulses;
      csum0 = csum_pulses;
      got_q.delete();
      got_cyc_q.delete();
      drive_track(idx, mode, start_at, bad_csum, k, exp_err);
      if (poke_body && !bad_csum) begin
         budget = 0;
         while (got_q.size() < 10 && budget < 50) begin
            tick();
            budget++;
         end
         vld = 1'b1;
         data = $urandom;
         tick();
         vld = 1'b0;
         exp_err++;
      end
      wait_idle("pkt");
      exp_pkt.push_back(32'(longint'(BASE_ADDR) + longint'(idx) * longint'(TRACK_STRIDE)));
      for (int i = 0; i < int'(TAP_NUM); i++) exp_pkt.push_back(taps[i]);
      if (bad_csum) begin
         check_eq("csum_no_pkt", got_q.size(), 32'd0);
         check_eq("csum_err_cnt", csum_pulses - csum0, 32'd1);
      end else begin
         check_eq("pkt_len", got_q.size(), exp_pkt.size());
         check_eq("csum_err_none", csum_pulses - csum0, 32'd0);
         if (got_q.size() == exp_pkt.size()) begin
            check_eq("hdr_cyc", got_cyc_q[0], k + 1);
            check_eq("last_cyc", got_cyc_q[TAP_NUM], k + 1 + TAP_NUM);
            foreach (exp_pkt[i]) check_eq("word", got_q[i], exp_pkt[i]);
            check_eq("cmd_run", run_q[$], TAP_NUM + 1);
         end
      end
      check_eq("tap_err_cnt", err_pulses - err0, exp_err);
   endtask

   initial begin
      int unsigned k, n_err, budget, err0, n0;
      repeat (3) tick();
      check_eq("rst_cmd", {31'b0, cmd}, 32'h0);
      check_eq("rst_vld", {31'b0, wr_vld}, 32'h0);
      check_eq("rst_data", wr_data, 32'h0);
      check_eq("rst_busy", {31'b0, busy}, 32'h0);
      check_eq("rst_err", {30'b0, tap_err, csum_err}, 32'h0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < int'(TAP_NUM); i++) taps[i] = 32'(i + 1);
      send_track(16'd3, 0, -1, 1'b0, 1'b0);
      send_track(16'd3, 1, -1, 1'b0, 1'b0);
      send_track(16'd3, 0, 40, 1'b0, 1'b0);

      // Stray tap word in IDLE
      err0 = err_pulses;
      got_q.delete();
      vld = 1'b1;
      data = 32'h0000_DEAD;
      tick();
      vld = 1'b0;
      data = '0;
      repeat (4) tick();
      check_eq("idle_vld_err", err_pulses - err0, 32'd1);
      check_eq("idle_vld_nopkt", got_q.size(), 32'd0);
      check_eq("idle_busy", {31'b0, busy}, 32'h0);

      // Reset while tap value 50 is on the bus
      got_q.delete();
      got_cyc_q.delete();
      drive_track(16'd3, 0, -1, 1'b0, k, n_err);
      budget = 0;
      while (got_q.size() < 51 && budget < 100) begin
         tick();
         budget++;
      end
      check_eq("pre_rst_words", got_q.size(), 32'd51);
      if (got_q.size() >= 51) check_eq("pre_rst_tap50", got_q[50], 32'd50);
      rst = 1'b1;
      tick();
      check_eq("mid_rst_cmd", {31'b0, cmd}, 32'h0);
      check_eq("mid_rst_vld", {31'b0, wr_vld}, 32'h0);
      check_eq("mid_rst_data", wr_data, 32'h0);
      check_eq("mid_rst_busy", {31'b0, busy}, 32'h0);
      rst = 1'b0;
      n0 = got_q.size();
      repeat (10) tick();
      check_eq("post_rst_quiet", got_q.size(), n0);
      for (int i = 0; i < int'(TAP_NUM); i++) taps[i] = $urandom;
      send_track(16'd0, 2, -1, 1'b0, 1'b0);

      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < int'(TAP_NUM); i++) taps[i] = $urandom;
         send_track(16'($urandom), 2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 120)) : -1,
                    1'b0, 1'($urandom_range(0, 1)));
      end

`ifdef FIR_TAP_CSUM_EN
      for (int i = 0; i < int'(TAP_NUM); i++) taps[i] = 32'd1;
      send_track(16'd7, 0, -1, 1'b0, 1'b0);
      send_track(16'd7, 0, -1, 1'b1, 1'b0);
      for (int i = 0; i < int'(TAP_NUM); i++) taps[i] = $urandom;
      send_track(16'($urandom), 2, -1, 1'b0, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
